// File: rtl/comm_pkg.sv
// +----------------------------------------------------------------------+
// | comm_pkg                                                             |
// | Shared definitions for the NEO link: message layout, receiver        |
// | threshold, default pulse timing and transmitter FSM states.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package comm_pkg;

  localparam int MSG_BITS     = 24;
  localparam int RX_THRESHOLD = 26;

  // Default pulse timing in clock cycles
  localparam int HIGH_ONE_DEF   = 40;
  localparam int HIGH_ZERO_DEF  = 12;
  localparam int LOW_CYCLES_DEF = 12;
  localparam int GAP_CYCLES_DEF = 64;

  // Message word, MSB first on the wire; also used by the receiver's sorter
  typedef struct packed {
    logic [8:0] ball_y;
    logic [3:0] vel_x;
    logic [3:0] vel_y;
    logic       sign_y;
    logic       ball_message;
    logic       are_you_there;
    logic       i_am_here;
    logic       miss_message;
    logic       i_lost;
    logic       new_game_message;
  } comm_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/communication_transmitter_if.sv
// +----------------------------------------------------------------------+
// | communication_transmitter_if                                         |
// | Request/field bundle between the game FSM and the NEO transmitter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface communication_transmitter_if;

  logic       send_message;
  logic [8:0] ball_y_tx;
  logic [3:0] velocity_x_tx;
  logic [3:0] velocity_y_tx;
  logic       sign_y_tx;
  logic       ball_message_tx;
  logic       are_you_there_tx;
  logic       i_am_here_tx;
  logic       miss_message_tx;
  logic       i_lost_tx;
  logic       new_game_message_tx;
  logic       tx_busy;
  logic       message_sent;
  logic       NEO_OUT;

  // Game FSM side
  modport master (
    output send_message, ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
           ball_message_tx, are_you_there_tx, i_am_here_tx, miss_message_tx,
           i_lost_tx, new_game_message_tx,
    input  tx_busy, message_sent, NEO_OUT
  );

  // Transmitter side
  modport slave (
    input  send_message, ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
           ball_message_tx, are_you_there_tx, i_am_here_tx, miss_message_tx,
           i_lost_tx, new_game_message_tx,
    output tx_busy, message_sent, NEO_OUT
  );

endinterface

`default_nettype wire

// File: rtl/message_packer.sv
// +----------------------------------------------------------------------+
// | message_packer                                                       |
// | Combinational assembly of a comm_msg_t from individual fields.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module message_packer
  import comm_pkg::*;
(
  input  logic       ball_y_i_en_unused_guard_n, // tied high by parent; keeps field list explicit
  input  logic [8:0] ball_y_i,
  input  logic [3:0] vel_x_i,
  input  logic [3:0] vel_y_i,
  input  logic       sign_y_i,
  input  logic       ball_message_i,
  input  logic       are_you_there_i,
  input  logic       i_am_here_i,
  input  logic       miss_message_i,
  input  logic       i_lost_i,
  input  logic       new_game_message_i,
  output comm_msg_t  msg_o
);

  // Field-by-field placement so the layout follows the struct definition
  always_comb begin
    msg_o                  = '0;
    msg_o.ball_y           = ball_y_i;
    msg_o.vel_x            = vel_x_i;
    msg_o.vel_y            = vel_y_i;
    msg_o.sign_y           = sign_y_i;
    msg_o.ball_message     = ball_message_i;
    msg_o.are_you_there    = are_you_there_i;
    msg_o.i_am_here        = i_am_here_i;
    msg_o.miss_message     = miss_message_i;
    msg_o.i_lost           = i_lost_i;
    msg_o.new_game_message = new_game_message_i & ball_y_i_en_unused_guard_n;
  end

endmodule

`default_nettype wire

// File: rtl/communication_transmitter.sv
// +----------------------------------------------------------------------+
// | communication_transmitter                                            |
// | Serialises one 24-bit game message onto the NEO line using pulse-    |
// | width encoding (long high = 1, short high = 0, fixed low gaps).      |
// | Optional macro CT_QUEUE_EN adds a one-entry pending request.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module communication_transmitter
  import comm_pkg::*;
#(
  parameter int HIGH_ONE   = HIGH_ONE_DEF,
  parameter int HIGH_ZERO  = HIGH_ZERO_DEF,
  parameter int LOW_CYCLES = LOW_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  communication_transmitter_if.slave  bus
);

  // Terminal counts of the shared 8-bit time counter
  localparam logic [7:0] ONE_LAST  = 8'(HIGH_ONE - 1);
  localparam logic [7:0] ZERO_LAST = 8'(HIGH_ZERO - 1);
  localparam logic [7:0] LOW_LAST  = 8'(LOW_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] GAP_PRE   = 8'(GAP_CYCLES - 2);
  localparam logic [4:0] BIT_LAST  = 5'(MSG_BITS - 1);

  comm_msg_t           packed_w;
  tx_state_e           state_q, state_d;
  logic [MSG_BITS-1:0] shift_q, shift_d;
  logic [7:0]          time_q, time_d;
  logic [4:0]          bit_q, bit_d;
  logic                neo_q;
  logic                sent_q, sent_d;
  logic                busy_w, accept_w, gap_end_w;
  logic [7:0]          high_last_w;

  message_packer u_packer (
    .ball_y_i_en_unused_guard_n (1'b1),
    .ball_y_i           (bus.ball_y_tx),
    .vel_x_i            (bus.velocity_x_tx),
    .vel_y_i            (bus.velocity_y_tx),
    .sign_y_i           (bus.sign_y_tx),
    .ball_message_i     (bus.ball_message_tx),
    .are_you_there_i    (bus.are_you_there_tx),
    .i_am_here_i        (bus.i_am_here_tx),
    .miss_message_i     (bus.miss_message_tx),
    .i_lost_i           (bus.i_lost_tx),
    .new_game_message_i (bus.new_game_message_tx),
    .msg_o              (packed_w)
  );

  assign high_last_w = shift_q[MSG_BITS-1] ? ONE_LAST : ZERO_LAST;
  assign gap_end_w   = (state_q == ST_GAP) && (time_q == GAP_LAST);

`ifdef CT_QUEUE_EN
  logic [MSG_BITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;

  // Only refuse when both the active and the pending slot are taken
  assign busy_w = (state_q != ST_IDLE) && pend_v_q;
`else
  assign busy_w = (state_q != ST_IDLE);
`endif

  assign accept_w = bus.send_message && !busy_w;

  // Next-state, counter and shift-register logic
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    time_d  = time_q + 8'd1;
    bit_d   = bit_q;
    sent_d  = 1'b0;
`ifdef CT_QUEUE_EN
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
`endif
    case (state_q)
      ST_IDLE: begin
        time_d = 8'd0;
        if (accept_w) begin
          state_d = ST_HIGH;
          shift_d = packed_w;
          bit_d   = 5'd0;
        end
      end
      ST_HIGH: begin
        if (time_q == high_last_w) begin
          time_d = 8'd0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_GAP;
            bit_d   = 5'd0;
          end else begin
            state_d = ST_LOW;
            shift_d = shift_q << 1;
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      ST_LOW: begin
        // Bit counter persists across LOW; it indexes the whole message
        if (time_q == LOW_LAST) begin
          state_d = ST_HIGH;
          time_d  = 8'd0;
        end
      end
      ST_GAP: begin
        // Registered pulse lands in the final GAP cycle
        if (time_q == GAP_PRE) sent_d = 1'b1;
        if (gap_end_w) begin
          time_d  = 8'd0;
          bit_d   = 5'd0;
          state_d = ST_IDLE;
`ifdef CT_QUEUE_EN
          if (pend_v_q) begin
            state_d  = ST_HIGH;
            shift_d  = pend_q;
            pend_v_d = 1'b0;
          end else if (accept_w) begin
            // Request arriving on the very last GAP cycle starts directly
            state_d = ST_HIGH;
            shift_d = packed_w;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        time_d  = 8'd0;
        bit_d   = 5'd0;
      end
    endcase
`ifdef CT_QUEUE_EN
    if (accept_w && (state_q != ST_IDLE) && !gap_end_w) begin
      pend_d   = packed_w;
      pend_v_d = 1'b1;
    end
`endif
  end

  // State, counters and the registered line driver
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      time_q  <= 8'd0;
      bit_q   <= 5'd0;
      neo_q   <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      time_q  <= time_d;
      bit_q   <= bit_d;
      neo_q   <= (state_d == ST_HIGH);
      sent_q  <= sent_d;
    end
  end

`ifdef CT_QUEUE_EN
  // Pending request slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end
`endif

  assign bus.NEO_OUT      = neo_q;
  assign bus.tx_busy      = busy_w;
  assign bus.message_sent = sent_q;

endmodule

`default_nettype wire

// File: tb/tb_communication_transmitter.sv
// +----------------------------------------------------------------------+
// | tb_communication_transmitter                                         |
// | Directed self-checking bench for communication_transmitter; decodes  |
// | NEO_OUT pulse widths back into the 24-bit word.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_communication_transmitter;

`ifdef CT_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  always #5 clock = ~clock;

  communication_transmitter_if bus();

  communication_transmitter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [23:0] got_a, got_b;
  int dur_a, bad_a, sent_a, pre_a;
  int dur_b, bad_b, sent_b, pre_b;
  int cnt, cnt2, rises;
  logic prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_fields(input logic [23:0] w);
    bus.ball_y_tx           = w[23:15];
    bus.velocity_x_tx       = w[14:11];
    bus.velocity_y_tx       = w[10:7];
    bus.sign_y_tx           = w[6];
    bus.ball_message_tx     = w[5];
    bus.are_you_there_tx    = w[4];
    bus.i_am_here_tx        = w[3];
    bus.miss_message_tx     = w[2];
    bus.i_lost_tx           = w[1];
    bus.new_game_message_tx = w[0];
  endtask

  // Called on a negedge; returns on the negedge of the first post-accept cycle
  task automatic request(input logic [23:0] w);
    set_fields(w);
    bus.send_message = 1'b1;
    @(negedge clock);
    bus.send_message = 1'b0;
    set_fields(24'h0);
  endtask

  // Decode one message from NEO_OUT; ends on the negedge after message_sent
  task automatic capture(output logic [23:0] got, output int dur, output int bad,
                         output int sent, output int pre);
    int w, l;
    bit done;
    got = '0; dur = 0; bad = 0; sent = 0; pre = 0;
    while (bus.NEO_OUT !== 1'b1 && pre < 300) begin
      pre++;
      @(negedge clock);
    end
    for (int k = 0; k < 24; k++) begin
      w = 0;
      while (bus.NEO_OUT === 1'b1 && w < 255) begin
        w++; dur++;
        if (bus.message_sent === 1'b1) sent++;
        @(negedge clock);
      end
      got = {got[22:0], (w > 26)};
      if (w != 40 && w != 12) bad++;
      l = 0;
      if (k < 23) begin
        while (bus.NEO_OUT === 1'b0 && l < 255) begin
          l++; dur++;
          if (bus.message_sent === 1'b1) sent++;
          @(negedge clock);
        end
        if (l != 12) bad++;
      end else begin
        done = 1'b0;
        while (!done && l < 255) begin
          l++; dur++;
          if (bus.NEO_OUT !== 1'b0) bad++;
          if (bus.message_sent === 1'b1) begin
            sent++;
            done = 1'b1;
          end
          @(negedge clock);
        end
        if (l != 64) bad++;
      end
    end
  endtask

  task automatic report(input string tag, input logic [23:0] got, input int dur,
                        input int bad, input int sent,
                        input logic [23:0] exp, input int exp_dur);
    chk({tag, "_data"}, got, exp);
    chk({tag, "_widths"}, bad, 0);
    chk({tag, "_duration"}, dur, exp_dur);
    chk({tag, "_sent"}, sent, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.send_message = 1'b0;
    set_fields(24'h0);
    repeat (3) @(negedge clock);
    chk("rst_neo", bus.NEO_OUT, 1'b0);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_sent", bus.message_sent, 1'b0);
    reset = 1'b0;

    // Idle for 100 cycles: nothing may move
    cnt = 0; cnt2 = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.NEO_OUT !== 1'b0 || bus.tx_busy !== 1'b0) cnt++;
      if (bus.message_sent !== 1'b0) cnt2++;
    end
    chk("idle_activity", cnt, 0);
    chk("idle_sent", cnt2, 0);

    // Ball message: fields pack to 1_1010_0101 0011 0101 1 1 00000 = 24'hD29AE0
    // 11 ones, 13 zeros: 11*40 + 13*12 + 23*12 + 64 = 936
    bus.ball_y_tx = 9'h1A5; bus.velocity_x_tx = 4'd3; bus.velocity_y_tx = 4'd5;
    bus.sign_y_tx = 1'b1; bus.ball_message_tx = 1'b1;
    bus.send_message = 1'b1;
    @(negedge clock);
    bus.send_message = 1'b0;
    chk("lat_neo", bus.NEO_OUT, 1'b1);
    chk("lat_busy", bus.tx_busy, QUEUE ? 1'b0 : 1'b1);
    capture(got_a, dur_a, bad_a, sent_a, pre_a);
    report("ball", got_a, dur_a, bad_a, sent_a, 24'hD29AE0, 936);

    // All zeros: 24*12 + 23*12 + 64 = 628
    request(24'h000000);
    capture(got_a, dur_a, bad_a, sent_a, pre_a);
    report("zeros", got_a, dur_a, bad_a, sent_a, 24'h000000, 628);

    // All ones: 24*40 + 23*12 + 64 = 1300
    request(24'hFFFFFF);
    capture(got_a, dur_a, bad_a, sent_a, pre_a);
    report("ones", got_a, dur_a, bad_a, sent_a, 24'hFFFFFF, 1300);

    // Reset asserted in the middle of bit 10's high pulse
    request(24'h000000);
    rises = 1; prev = 1'b1; cnt = 0;
    while (rises < 11 && cnt < 2000) begin
      @(negedge clock);
      cnt++;
      if (bus.NEO_OUT === 1'b1 && prev !== 1'b1) rises++;
      prev = bus.NEO_OUT;
    end
    chk("mid_reached_bit10", rises, 11);
    repeat (3) @(negedge clock);
    chk("mid_pre_neo", bus.NEO_OUT, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_neo", bus.NEO_OUT, 1'b0);
    chk("mid_rst_busy", bus.tx_busy, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    // 24'h000001: 40 + 23*12 + 23*12 + 64 = 656
    request(24'h000001);
    capture(got_a, dur_a, bad_a, sent_a, pre_a);
    report("post_rst", got_a, dur_a, bad_a, sent_a, 24'h000001, 656);

    // send_message held high: back-to-back 24'h5A5A5A (12 ones): 480+144+276+64 = 964
    set_fields(24'h5A5A5A);
    bus.send_message = 1'b1;
    @(negedge clock);
    capture(got_a, dur_a, bad_a, sent_a, pre_a);
    report("b2b_first", got_a, dur_a, bad_a, sent_a, 24'h5A5A5A, 964);
    // After the 64 GAP cycles the unqueued build spends one IDLE cycle accepting
    cnt = 0;
    while (bus.NEO_OUT !== 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clock);
    end
    bus.send_message = 1'b0;
    chk("b2b_extra_low", cnt, QUEUE ? 0 : 1);
    capture(got_a, dur_a, bad_a, sent_a, pre_a);
    report("b2b_second", got_a, dur_a, bad_a, sent_a, 24'h5A5A5A, 964);
    cnt = 0;
    repeat (150) begin
      @(negedge clock);
      if (bus.NEO_OUT !== 1'b0 || bus.message_sent !== 1'b0) cnt++;
    end
    chk("b2b_drain", cnt, 0);

    // Two requests 5 cycles apart: C00003 (4 ones) and 00000F (4 ones), 740 each
    request(24'hC00003);
    chk("q_busy_after_first", bus.tx_busy, QUEUE ? 1'b0 : 1'b1);
    fork
      capture(got_a, dur_a, bad_a, sent_a, pre_a);
      begin
        repeat (4) @(negedge clock);
        request(24'h00000F);
        chk("q_busy_after_second", bus.tx_busy, 1'b1);
      end
    join
    report("q_first", got_a, dur_a, bad_a, sent_a, 24'hC00003, 740);
    if (QUEUE) begin
      capture(got_b, dur_b, bad_b, sent_b, pre_b);
      chk("q_no_idle", pre_b, 0);
      report("q_second", got_b, dur_b, bad_b, sent_b, 24'h00000F, 740);
    end else begin
      cnt = 0;
      repeat (150) begin
        @(negedge clock);
        if (bus.NEO_OUT !== 1'b0 || bus.message_sent !== 1'b0) cnt++;
      end
      chk("q_dropped", cnt, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
